lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store memory port: the consumer of the 4-bit read_write code produced by the ID-stage control unit.
- Decodes the access kind and performs byte-lane steering on store data.
- Runs a request/grant/response handshake to the data memory and aligns and extends load data for MEM/WB.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, cycles in REQ/WAIT before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  EX/MEM presents an access this cycle.
- rw_i  in  4  read_write code. bit3 = valid. LB=1000, LH=1001, LW=1010, LBU=1100, LHU=1101, SB=1011, SH=1110, SW=1111.
- addr_i  in  ADDR_W  byte address (ALU result).
- wdata_i  in  32  store data (rs2).
- stall_o  out  1  hold pipeline.
- done_o  out  1  one-cycle completion pulse.
- load_data_o  out  32  extended load result; valid with done_o.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- mem_req_o  out  1  request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-steered write data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset: state IDLE. All outputs and all registers are 0.
- FSM states: IDLE, REQ, WAIT.
- Accept: in IDLE, when start_i & rw_i[3], the block latches op, addr and wdata.
  - Aligned access: go to REQ next cycle with mem_req_o=1.
  - Misaligned access: stay in IDLE, issue no request, pulse misalign_o next cycle, never assert done_o.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- rw_i[3]=0 is a no-op. start_i is ignored outside IDLE.
- stall_o is combinational: (state!=IDLE) | (IDLE & start_i & rw_i[3] & aligned).
- REQ: mem_req_o and all mem_* outputs are held stable until mem_gnt_i.
  - Store + gnt: go to IDLE; done_o pulses next cycle.
  - Load + gnt, no rvalid: go to WAIT.
  - Load + gnt + rvalid in the same cycle: go to IDLE and complete as if from WAIT.
- WAIT: mem_req_o=0. On rvalid, go to IDLE, load_data_o updates, and done_o pulses the following cycle.
  - load_data_o holds its value until the next load completes.
- mem_rvalid_i seen in IDLE or REQ without gnt is ignored.
- Minimum latency, accept to done_o, zero-wait-state memory:
  - store: 2 cycles.
  - load: 2 cycles (gnt and rvalid together) or 3 cycles.
- Store steering:
  - SB: be = 4'b0001<<addr[1:0]; wdata = wdata_i[7:0] replicated x4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = wdata_i[15:0] replicated x2.
  - SW: be = 4'b1111; wdata = wdata_i.
- Loads: mem_we_o=0, be=4'b1111.
  - Result byte = rdata[8*addr[1:0] +: 8], extended: sign for LB, zero for LBU.
  - Result halfword = rdata[16*addr[1] +: 16], extended: sign for LH, zero for LHU.
  - LW: result = rdata.
- Reset mid-operation: mem_req_o drops immediately (asynchronous). A late rvalid arriving after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES:
  - go to IDLE and drop mem_req_o;
  - pulse bus_err_o next cycle; done_o is not asserted;
  - a response arriving after the abort is ignored.
- Undefined: bus_err_o is tied 0, no counter exists, and the block waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - rw_code_t enum holding the eight codes above;
  - lsu_state_t enum {IDLE, REQ, WAIT};
  - functions is_load(rw) and is_misaligned(rw, addr[1:0]).
- One combinational sub-module, lsu_load_align: inputs rdata, addr[1:0] and rw code; output is the extended 32-bit result. It is reusable by a future cache path.

Test Plan:
- SB, addr=0x1002, wdata=0xA5, gnt on first REQ cycle -> mem_be=4'b0100, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, we=1; done_o 2 cycles after accept.
- LB, addr=0x2003, rdata=0x80FF_1234 returned 3 cycles after gnt -> load_data_o=0xFFFF_FF80; stall_o high until done; LBU same stimulus -> 0x0000_0080.
- LHU, addr=0x2002, rdata=0xBEEF_0000, gnt+rvalid same cycle -> load_data_o=0x0000_BEEF; done_o 2 cycles after accept; LH same -> 0xFFFF_BEEF.
- SW, addr=0x3001 -> no mem_req_o, misalign_o pulses once, done_o stays 0; LH at 0x3001 -> same response.
- Load with mem_gnt_i withheld 5 cycles -> mem_req_o/addr/be stable all 5 cycles; rst_n asserted while in WAIT -> mem_req_o=0 immediately, a later rvalid produces no done_o.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted -> bus_err_o pulses once, mem_req_o drops, next access accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access codes, FSM states and decode helpers
// shared by the load/store memory port and its load aligner.
package lsu_pkg;

  typedef enum logic [3:0] {
    RW_LB  = 4'b1000,
    RW_LH  = 4'b1001,
    RW_LW  = 4'b1010,
    RW_SB  = 4'b1011,
    RW_LBU = 4'b1100,
    RW_LHU = 4'b1101,
    RW_SH  = 4'b1110,
    RW_SW  = 4'b1111
  } rw_code_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  function automatic logic is_load(logic [3:0] rw);
    return rw[3] && !(rw inside {RW_SB, RW_SH, RW_SW});
  endfunction

  function automatic logic is_misaligned(logic [3:0] rw,
                                         logic [1:0] a);
    logic half;
    logic word;
    half = rw inside {RW_LH, RW_LHU, RW_SH};
    word = rw inside {RW_LW, RW_SW};
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_align.sv
// lsu_load_align: picks the addressed byte/halfword out of a
// read word and sign- or zero-extends it for writeback.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  rw_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata_i[{off_i, 3'b000} +: 8];
  assign h = rdata_i[{off_i[1], 4'b0000} +: 16];

  // extend the selected lane according to the load kind
  always_comb begin
    data_o = rdata_i;
    unique case (1'b1)
      rw_i == RW_LB:  data_o = {{24{b[7]}}, b};
      rw_i == RW_LBU: data_o = {24'b0, b};
      rw_i == RW_LH:  data_o = {{16{h[15]}}, h};
      rw_i == RW_LHU: data_o = {16'b0, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: request/grant/response port to data memory.
// Optional abort on a stuck bus: define LSU_TIMEOUT_EN.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [3:0]        rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  lsu_state_t        state_q;
  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic              req_q;
  logic              we_q;
  logic              done_q;
  logic              mis_q;
  logic              berr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_q;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       ld_d;
  logic              acc;
  logic              mis;
  logic              tmo;

  assign acc = start_i & rw_i[3];
  assign mis = is_misaligned(rw_i, addr_i[1:0]);

  assign stall_o = (state_q != IDLE) | (acc & ~mis);

  // store lane steering; loads read the whole word
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    unique case (1'b1)
      rw_i == RW_SB: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      rw_i == RW_SH: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rdata_i (mem_rdata_i),
    .off_i   (off_q),
    .rw_i    (op_q),
    .data_o  (ld_d)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CW < 8) ? 8 : CW;

  logic [CNT_W-1:0] cnt_q;

  // cycles spent on the current access; restarts in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tmo = (state_q != IDLE) &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  // access FSM with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            op_q  <= rw_i;
            off_q <= addr_i[1:0];
            if (mis) begin
              mis_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              we_q    <= ~is_load(rw_i);
              addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            req_q <= 1'b0;
            if (!is_load(op_q)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (mem_rvalid_i) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              ld_q    <= ld_d;
            end else begin
              state_q <= WAIT;
            end
          end else if (tmo) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            berr_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ld_q    <= ld_d;
          end else if (tmo) begin
            state_q <= IDLE;
            berr_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o      = done_q;
  assign misalign_o  = mis_q;
  assign bus_err_o   = berr_q;
  assign load_data_o = ld_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed access sequences checked every
// cycle against an arithmetic model of the port's behaviour.
module tb_lsu_mem_port;

  localparam logic [3:0] C_LB  = 4'b1000;
  localparam logic [3:0] C_LH  = 4'b1001;
  localparam logic [3:0] C_LW  = 4'b1010;
  localparam logic [3:0] C_SB  = 4'b1011;
  localparam logic [3:0] C_LBU = 4'b1100;
  localparam logic [3:0] C_LHU = 4'b1101;
  localparam logic [3:0] C_SH  = 4'b1110;
  localparam logic [3:0] C_SW  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  rw_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o, done_o, misalign_o, bus_err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] load_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  logic        exp_stall = 0, exp_done = 0, exp_mis = 0;
  logic        exp_berr = 0, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wd = 0, exp_ld = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] snap_addr, snap_wd;
  logic [3:0]  snap_be;
  logic        snap_we;
  int total = 0, bad = 0, mis_cnt = 0, berr_cnt = 0;
  int lat;

  lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .rw_i(rw_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic is_ld(logic [3:0] rw);
    return rw == C_LB || rw == C_LH || rw == C_LW ||
           rw == C_LBU || rw == C_LHU;
  endfunction

  function automatic logic mis_model(logic [3:0] rw,
                                     logic [31:0] a);
    logic half, word;
    half = rw == C_LH || rw == C_LHU || rw == C_SH;
    word = rw == C_LW || rw == C_SW;
    return (half && a % 2 != 0) || (word && a % 4 != 0);
  endfunction

  function automatic logic [3:0] be_model(logic [3:0] rw,
                                          logic [31:0] a);
    if (rw == C_SB) begin
      case (a % 4)
        0: return 4'h1;
        1: return 4'h2;
        2: return 4'h4;
        default: return 4'h8;
      endcase
    end
    if (rw == C_SH) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(logic [3:0] rw,
                                           logic [31:0] d);
    if (rw == C_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (rw == C_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ld_model(logic [3:0] rw,
                                           logic [31:0] a,
                                           logic [31:0] d);
    logic [31:0] v;
    v = d;
    if (rw == C_LB || rw == C_LBU) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (rw == C_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (rw == C_LH || rw == C_LHU) begin
      v = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (rw == C_LH && v >= 32'h8000)
        v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    chk("stall", stall_o, exp_stall);
    chk("done", done_o, exp_done);
    chk("misalign", misalign_o, exp_mis);
    chk("bus_err", bus_err_o, exp_berr);
    chk("req", mem_req_o, exp_req);
    chk("load_data", load_data_o, exp_ld);
    if (exp_req) begin
      chk("we", mem_we_o, exp_we);
      chk("addr", mem_addr_o, exp_addr);
      chk("be", mem_be_o, exp_be);
      if (exp_we) chk("wdata", mem_wdata_o, exp_wd);
    end
    if (misalign_o === 1'b1) mis_cnt++;
    if (bus_err_o === 1'b1) berr_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    start_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    exp_done = 0; exp_mis = 0; exp_berr = 0;
    exp_stall = 0; exp_req = 0;
  endtask

  task automatic step(inout int k, inout int l);
    cyc();
    k++;
    if (done_o === 1'b1 && l < 0) l = k;
  endtask

  task automatic reset_mid();
    #2;
    rst_n = 0; start_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    exp_stall = 0; exp_req = 0; exp_ld = 0;
    #1;
    chk("rst_req_drop", mem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    cyc();
    chk("late_rv_done", done_o, 0);
  endtask

  // mode: 0 normal, 1 reset in REQ, 2 reset in WAIT, 3 no grant
  task automatic do_access(input logic [3:0] rw,
                           input logic [31:0] a, wd,
                           input int gd, rd,
                           input logic [31:0] rdat,
                           input int mode, output int l);
    logic ld, mis;
    int k;
    ld = is_ld(rw);
    mis = mis_model(rw, a);
    l = -1;
    k = 0;
    cyc();
    start_i = 1; rw_i = rw; addr_i = a; wdata_i = wd;
    exp_stall = !mis;
    if (mis) begin
      step(k, l);
      exp_mis = 1;
      step(k, l);
      step(k, l);
      return;
    end
    exp_we = !ld;
    exp_addr = a & ~32'h3;
    exp_be = be_model(rw, a);
    exp_wd = wd_model(rw, wd);
    for (int i = 0; i <= gd; i++) begin
      step(k, l);
      start_i = 1; rw_i = C_SB;
      addr_i = 32'hFFFF_FFF0; wdata_i = 32'h1357_9BDF;
      exp_stall = 1; exp_req = 1;
      if (i == 0) begin
        snap_be = mem_be_o; snap_wd = mem_wdata_o;
        snap_addr = mem_addr_o; snap_we = mem_we_o;
      end
      if (i < gd || mode == 3) begin
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
      end else if (mode == 1) begin
        reset_mid();
        return;
      end else begin
        mem_gnt_i = 1;
        mem_rvalid_i = ld && rd == 0;
        mem_rdata_i = rdat;
      end
    end
    if (ld && mode != 3) begin
      for (int j = 1; j <= rd; j++) begin
        step(k, l);
        start_i = 1; rw_i = C_SW; exp_stall = 1;
        if (mode == 2) begin
          reset_mid();
          return;
        end
        mem_rvalid_i = (j == rd);
        mem_rdata_i = (j == rd) ? rdat : 32'hBAD1_BAD1;
      end
    end
    step(k, l);
    if (mode == 3) begin
      exp_berr = 1;
    end else begin
      exp_done = 1;
      if (ld) exp_ld = ld_model(rw, a, rdat);
    end
    step(k, l);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    #1 rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    chk("rst_req_o", mem_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ld", load_data_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);

    do_access(C_SB, 32'h1002, 32'hA5, 0, 0, 0, 0, lat);
    chk("sb_be", snap_be, 4'b0100);
    chk("sb_wd", snap_wd, 32'hA5A5_A5A5);
    chk("sb_addr", snap_addr, 32'h1000);
    chk("sb_we", snap_we, 1);
    chk("sb_lat", lat, 2);

    do_access(C_LB, 32'h2003, 0, 0, 3, 32'h80FF_1234, 0, lat);
    chk("lb_data", load_data_o, 32'hFFFF_FF80);
    chk("lb_lat", lat, 5);
    do_access(C_LBU, 32'h2003, 0, 0, 3, 32'h80FF_1234, 0, lat);
    chk("lbu_data", load_data_o, 32'h0000_0080);

    do_access(C_LHU, 32'h2002, 0, 0, 0, 32'hBEEF_0000, 0, lat);
    chk("lhu_data", load_data_o, 32'h0000_BEEF);
    chk("lhu_lat", lat, 2);
    do_access(C_LH, 32'h2002, 0, 0, 0, 32'hBEEF_0000, 0, lat);
    chk("lh_data", load_data_o, 32'hFFFF_BEEF);

    m0 = mis_cnt;
    do_access(C_SW, 32'h3001, 32'h1, 0, 0, 0, 0, lat);
    chk("sw_mis_cnt", mis_cnt - m0, 1);
    chk("sw_mis_nodone", lat, -1);
    m0 = mis_cnt;
    do_access(C_LH, 32'h3001, 0, 0, 0, 0, 0, lat);
    chk("lh_mis_cnt", mis_cnt - m0, 1);
    chk("lh_mis_nodone", lat, -1);
    chk("mis_ld_hold", load_data_o, 32'hFFFF_BEEF);

    do_access(C_SH, 32'h2006, 32'h1234_ABCD, 2, 0, 0, 0, lat);
    chk("sh_be", snap_be, 4'b1100);
    chk("sh_wd", snap_wd, 32'hABCD_ABCD);
    chk("sh_lat", lat, 4);
    do_access(C_SB, 32'h0003, 32'h7E, 0, 0, 0, 0, lat);
    chk("sb3_be", snap_be, 4'b1000);
    do_access(C_LW, 32'h0010, 0, 1, 1, 32'h1234_5678, 0, lat);
    chk("lw_data", load_data_o, 32'h1234_5678);
    chk("lw_lat", lat, 4);
    do_access(C_LBU, 32'h0011, 0, 0, 0, 32'h0000_9A00, 0, lat);
    chk("lbu1_data", load_data_o, 32'h0000_009A);

    do_access(C_LW, 32'h4008, 0, 5, 2, 32'h0, 2, lat);
    chk("wait_rst_nodone", lat, -1);
    do_access(C_LH, 32'h400A, 0, 2, 0, 32'h0, 1, lat);
    chk("req_rst_nodone", lat, -1);
    chk("post_rst_ld", load_data_o, 0);

    do_access(C_SW, 32'h0044, 32'hDEAD_BEEF, 0, 0, 0, 0, lat);
    chk("sw_wd", snap_wd, 32'hDEAD_BEEF);
    chk("sw_lat", lat, 2);

`ifdef LSU_TIMEOUT_EN
    do_access(C_SW, 32'h5000, 32'h0, 7, 0, 0, 3, lat);
    chk("tmo_nodone", lat, -1);
    chk("tmo_berr_cnt", berr_cnt, 1);
    do_access(C_SW, 32'h5004, 32'h55, 0, 0, 0, 0, lat);
    chk("tmo_next_lat", lat, 2);
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
